// File: rtl/bpu_btb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb_pkg
// Purpose  : Shared constants and direction-counter encodings for bpu_btb.
// Revision : 1.0 - initial release
// ============================================================================
package bpu_btb_pkg;

  localparam int BPU_ENTRIES = 16;
  localparam int PC_INC      = 4;

  // Counter encodings derived from the counter width
  function automatic int ctr_weak_t(input int bits);
    return 1 << (bits - 1);
  endfunction

  function automatic int ctr_strong_t(input int bits);
    return (1 << bits) - 1;
  endfunction

  function automatic int ctr_strong_nt(input int bits);
    return (bits > 0) ? 0 : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_btb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : bpu_sat_counter
// Purpose  : Saturating up/down direction counter with synchronous load.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_sat_counter
  import bpu_btb_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                inc,
  input  logic                en,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  output logic [CTR_BITS-1:0] value
);

  localparam logic [CTR_BITS-1:0] C_MAX = CTR_BITS'(ctr_strong_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_MIN = CTR_BITS'(ctr_strong_nt(CTR_BITS));

  // Load (reset or allocation) wins over training
  always_ff @(posedge clk) begin
    if (load) begin
      value <= load_val;
    end else if (en) begin
      if (inc) begin
        if (value != C_MAX) value <= value + CTR_BITS'(1);
      end else begin
        if (value != C_MIN) value <= value - CTR_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb
// Purpose  : Direct-mapped BTB with per-entry saturating direction counters;
//            zero-latency fetch prediction and EX-stage mispredict/redirect.
//            Optional statistics counters under BPU_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int ENTRIES  = BPU_ENTRIES,
  parameter int PC_WIDTH = 32,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                stall,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic                ex_taken,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                ex_pred_taken,
  input  logic [PC_WIDTH-1:0] ex_pred_target,
  output logic                mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_W-1:0]    tag_mem [ENTRIES];
  logic [PC_WIDTH-1:0] tgt_mem [ENTRIES];
  logic [CTR_BITS-1:0] ctr     [ENTRIES];

  logic [IDX-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             upd, train, alloc, alias_kill;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[PC_WIDTH-1:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[PC_WIDTH-1:IDX+2];

  // Prediction reads pre-edge table contents; suppressed while in reset
  assign if_hit      = valid[if_idx] && (tag_mem[if_idx] == if_tag);
  assign pred_taken  = !rst && if_hit && ctr[if_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? tgt_mem[if_idx] : if_pc + PC_WIDTH'(PC_INC);

  assign mispredict = ex_valid && (
                        (ex_is_branch && (ex_taken != ex_pred_taken)) ||
                        (ex_is_branch && ex_taken && ex_pred_taken &&
                         (ex_target != ex_pred_target)) ||
                        (!ex_is_branch && ex_pred_taken));
  assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target
                                                  : ex_pc + PC_WIDTH'(PC_INC);

  assign ex_hit     = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
  assign upd        = ex_valid && !stall && !rst;
  assign train      = upd && ex_is_branch && ex_hit;
  assign alloc      = upd && ex_is_branch && !ex_hit && ex_taken;
  assign alias_kill = upd && !ex_is_branch && ex_pred_taken;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bpu_sat_counter #(
      .CTR_BITS (CTR_BITS)
    ) u_ctr (
      .clk      (clk),
      .inc      (ex_taken),
      .en       (train && (ex_idx == IDX'(i))),
      .load     (rst || (alloc && (ex_idx == IDX'(i)))),
      .load_val (rst ? CTR_BITS'(INIT_CTR) : CTR_BITS'(ctr_weak_t(CTR_BITS))),
      .value    (ctr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (alloc) begin
      valid[ex_idx] <= 1'b1;
    end else if (alias_kill) begin
      valid[ex_idx] <= 1'b0;
    end
  end

  // Tags and targets need no reset: valid bits qualify them
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_mem[ex_idx] <= ex_tag;
      tgt_mem[ex_idx] <= ex_target;
    end else if (train && ex_taken) begin
      tgt_mem[ex_idx] <= ex_target;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt, mp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (ex_valid && !stall) begin
      if (ex_is_branch && (br_cnt != '1)) br_cnt <= br_cnt + 32'd1;
      if (mispredict && (mp_cnt != '1))   mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign stat_branches    = br_cnt;
  assign stat_mispredicts = mp_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpu_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_btb
// Purpose  : Directed table-driven bench for bpu_btb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  bpu_btb dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .stall            (stall),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic        rst;
    logic [31:0] if_pc;
    logic        stall;
    logic        ev;
    logic        br;
    logic [31:0] epc;
    logic        tk;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
    logic        x_pt;
    logic [31:0] x_ptg;
    logic        x_mp;
    logic [31:0] x_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   row    = 0;
  logic stats_known = 1'b0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mp = '0;

  function automatic vec_t mk(logic r, logic [31:0] ip, logic st, logic ev, logic br,
                              logic [31:0] epc, logic tk, logic [31:0] etg, logic ept,
                              logic [31:0] eptg, logic xpt, logic [31:0] xptg,
                              logic xmp, logic [31:0] xrd);
    vec_t v;
    v.rst = r; v.if_pc = ip; v.stall = st; v.ev = ev; v.br = br; v.epc = epc;
    v.tk = tk; v.etg = etg; v.ept = ept; v.eptg = eptg; v.x_pt = xpt;
    v.x_ptg = xptg; v.x_mp = xmp; v.x_rd = xrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; if_pc = v.if_pc; stall = v.stall; ex_valid = v.ev;
    ex_is_branch = v.br; ex_pc = v.epc; ex_taken = v.tk; ex_target = v.etg;
    ex_pred_taken = v.ept; ex_pred_target = v.eptg;
    @(negedge clk);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, v.x_pt});
    chk("pred_target", pred_target, v.x_ptg);
    chk("mispredict", {31'd0, mispredict}, {31'd0, v.x_mp});
    if (v.x_mp) chk("redirect_pc", redirect_pc, v.x_rd);
    if (stats_known) begin
`ifdef BPU_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
`else
      chk("stat_branches", stat_branches, 32'd0);
      chk("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    end
    @(posedge clk);
    if (v.rst) begin
      m_br = '0; m_mp = '0; stats_known = 1'b1;
    end else if (v.ev && !v.stall) begin
      if (v.br) m_br++;
      if (v.x_mp) m_mp++;
    end
    #1;
    row++;
  endtask

  initial begin
    // rst, if_pc, stall, ev, br, ex_pc, tk, ex_tgt, ept, ept_tgt | pt, ptg, mp, redirect
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h44, 0, 32'h0));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0,  0, 32'h44, 1, 32'h80));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0));
    // counter at 3: four not-taken walk it to 0
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h44));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h44));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 0, 32'h80, 0, 32'h0,  0, 32'h44, 0, 32'h0));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 0, 32'h80, 0, 32'h0,  0, 32'h44, 0, 32'h0));
    // counter clamped at 0: two taken needed to predict taken again
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0,  0, 32'h44, 1, 32'h80));
    vecs.push_back(mk(0, 32'h40, 0, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0,  0, 32'h44, 1, 32'h80));
    // alias at 0x440: same index, different tag
    vecs.push_back(mk(0, 32'h440, 0, 1, 0, 32'h440, 0, 32'h0, 0, 32'h0, 0, 32'h444, 0, 32'h0));
    vecs.push_back(mk(0, 32'h40, 0, 1, 0, 32'h40, 0, 32'h0,  1, 32'h80, 1, 32'h80, 1, 32'h44));
    // entry invalidated; bubble inputs must not raise mispredict
    vecs.push_back(mk(0, 32'h40, 0, 0, 1, 32'h40, 1, 32'h80, 0, 32'h0,  0, 32'h44, 0, 32'h0));
    // stalled update: mispredict reported, table unchanged
    vecs.push_back(mk(0, 32'h108, 1, 1, 1, 32'h108, 1, 32'h200, 0, 32'h0, 0, 32'h10C, 1, 32'h200));
    vecs.push_back(mk(0, 32'h108, 0, 1, 1, 32'h108, 1, 32'h200, 0, 32'h0, 0, 32'h10C, 1, 32'h200));
    // target mismatch with both taken
    vecs.push_back(mk(0, 32'h108, 0, 1, 1, 32'h108, 1, 32'h200, 1, 32'h1F0, 1, 32'h200, 1, 32'h200));
    vecs.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h200, 0, 32'h0));
    // allocate, then reset before the following fetch
    vecs.push_back(mk(0, 32'h20C, 0, 1, 1, 32'h20C, 1, 32'h300, 0, 32'h0, 0, 32'h210, 1, 32'h300));
    vecs.push_back(mk(1, 32'h20C, 0, 1, 1, 32'h20C, 1, 32'h300, 0, 32'h0, 0, 32'h210, 1, 32'h300));
    vecs.push_back(mk(0, 32'h20C, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h210, 0, 32'h0));
    vecs.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10C, 0, 32'h0));
    // fetch PC wraps
    vecs.push_back(mk(0, 32'hFFFFFFFC, 0, 1, 0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));

    rst = 1'b1; if_pc = '0; stall = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Back-to-back: real mispredict, then the flushed bubble, then a fresh hit
    apply(mk(0, 32'h80, 0, 1, 1, 32'h80, 1, 32'h500, 0, 32'h0, 0, 32'h84, 1, 32'h500));
    apply(mk(0, 32'h80, 0, 0, 1, 32'h80, 0, 32'h0,  1, 32'h500, 1, 32'h500, 0, 32'h0));
    apply(mk(0, 32'h80, 0, 1, 1, 32'h80, 0, 32'h0,  1, 32'h500, 1, 32'h500, 1, 32'h84));
    apply(mk(0, 32'h80, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h84, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
